// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: DATA_W-bit MSB-first words, CLK_DIV clk per SCLK half-period,
// runtime CPOL/CPHA, NUM_SS active-low selects. Define SPI_BURST_EN for back-to-back words under one select.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 2,
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [1:0]        mode,
    output logic              data_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              cpol, cpol_n, cpha, cpha_n;
    logic [NUM_SS-1:0] ss_n;
    logic              sclk_n, mosi_n, data_ready_n, rx_valid_n;
    logic [DATA_W-1:0] rx_data_n;
    logic              half_done, leading;

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (32'(sel) == i) v[i] = 1'b0;
        return v;
    endfunction

    // Handshake: a word is accepted on any posedge where send && data_ready; send is ignored otherwise.
    always_comb begin
        state_n    = state;
        div_n      = div_cnt;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        cpol_n     = cpol;
        cpha_n     = cpha;
        ss_n       = SS;
        sclk_n     = SCLK;
        mosi_n     = MOSI;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        half_done  = (div_cnt == DIV_LAST);
        leading    = (SCLK == cpol);
        case (state)
            IDLE: begin
                sclk_n = mode[1];
                ss_n   = '1;
                div_n  = '0;
                if (send && data_ready) begin
                    state_n = SETUP;
                    shreg_n = tx_data;
                    cpol_n  = mode[1];
                    cpha_n  = mode[0];
                    ss_n    = ss_decode(ss_sel);
                    if (!mode[0]) mosi_n = tx_data[DATA_W-1];
                end
            end
            SETUP: begin
                sclk_n = cpol;
                div_n  = div_cnt + DIV_W'(1);
                if (half_done) begin
                    div_n   = '0;
                    bit_n   = BIT_LAST;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                div_n = div_cnt + DIV_W'(1);
                if (half_done) begin
                    div_n  = '0;
                    sclk_n = ~SCLK;
                    // Shifting on the sample edge leaves the next transmit bit in the MSB.
                    if (leading) begin
                        if (cpha) mosi_n = shreg[DATA_W-1];
                        else      shreg_n = {shreg[DATA_W-2:0], MISO};
                    end else begin
                        if (cpha) shreg_n = {shreg[DATA_W-2:0], MISO};
                        if (bit_cnt == '0) begin
                            state_n = HOLD;
                        end else begin
                            bit_n = bit_cnt - BIT_W'(1);
                            if (!cpha) mosi_n = shreg[DATA_W-1];
                        end
                    end
                end
            end
            HOLD: begin
                sclk_n = cpol;
                div_n  = div_cnt + DIV_W'(1);
                if (half_done) begin
                    div_n      = '0;
                    rx_data_n  = shreg;
                    rx_valid_n = 1'b1;
                    if (BURST && send && data_ready) begin
                        state_n = SHIFT;
                        shreg_n = tx_data;
                        mosi_n  = tx_data[DATA_W-1];
                        bit_n   = BIT_LAST;
                    end else begin
                        state_n = IDLE;
                        ss_n    = '1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        data_ready_n = (state_n == IDLE) || (BURST && state_n == HOLD && div_n == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            SS         <= '1;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            data_ready <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            cpol       <= cpol_n;
            cpha       <= cpha_n;
            SS         <= ss_n;
            SCLK       <= sclk_n;
            MOSI       <= mosi_n;
            data_ready <= data_ready_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, CLK_DIV=2, NUM_SS=2) with an SPI slave model
// and a queue scoreboard of expected received words.
module tb_spi_master_param;

    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 2;
    localparam int NUM_SS  = 2;
    localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int XFER    = CLK_DIV * (2 * DATA_W + 2);
`ifdef SPI_BURST_EN
    localparam int BUSY_EXP  = XFER - 1;
    localparam int GAP_EXP   = 2 * DATA_W * CLK_DIV + CLK_DIV;
    localparam int SS_HI_EXP = 0;
`else
    localparam int BUSY_EXP  = XFER;
    localparam int GAP_EXP   = XFER + 1;
    localparam int SS_HI_EXP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              send = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic [SS_W-1:0]   ss_sel = '0;
    logic [1:0]        mode = 2'b00;
    logic              data_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              sclk, mosi, miso;
    logic [NUM_SS-1:0] ss;

    spi_master_param #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_SS(NUM_SS)) dut (
        .clk(clk), .rst(rst), .send(send), .tx_data(tx_data), .ss_sel(ss_sel), .mode(mode),
        .data_ready(data_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS(ss)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // slave model: samples and drives per cur_mode while any select is low
    logic              loopback = 1'b1;
    logic [1:0]        cur_mode = 2'b00;
    logic [DATA_W-1:0] slave_tx = '0;
    logic [DATA_W-1:0] s_sh = '0;
    logic [DATA_W-1:0] s_rx = '0;
    logic              miso_s = 1'b0;
    logic              s_prev_idle = 1'b1;
    wire               ss_idle = &ss;

    assign miso = loopback ? mosi : miso_s;

    always @(sclk or ss_idle) begin
        if (ss_idle !== s_prev_idle) begin
            s_prev_idle = ss_idle;
            if (!ss_idle) begin
                s_sh   = slave_tx;
                s_rx   = '0;
                miso_s = cur_mode[0] ? 1'b0 : slave_tx[DATA_W-1];
            end
        end else if (!ss_idle) begin
            if ((sclk != cur_mode[1]) ^ cur_mode[0]) begin
                s_rx = {s_rx[DATA_W-2:0], mosi};
            end else if (cur_mode[0]) begin
                miso_s = s_sh[DATA_W-1];
                s_sh   = s_sh << 1;
            end else begin
                s_sh   = s_sh << 1;
                miso_s = s_sh[DATA_W-1];
            end
        end
    end

    // MOSI may only move together with an SCLK drive edge while a select is held
    int   mosi_bad = 0;
    logic mon_prev_active = 1'b0;
    logic mon_prev_mosi = 1'b0;
    logic mon_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (!ss_idle && mon_prev_active && mosi !== mon_prev_mosi)
            if (!(sclk !== mon_prev_sclk && ((sclk != cur_mode[1]) == cur_mode[0])))
                mosi_bad++;
        mon_prev_active = !ss_idle;
        mon_prev_mosi   = mosi;
        mon_prev_sclk   = sclk;
    end

    // scoreboard
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] sb_exp;
    int checks = 0;
    int errors = 0;
    int rx_valid_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample_rx();
        if (rx_valid === 1'b1) begin
            rx_valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(sb_exp));
            end
        end
    endtask

    // driver tasks
    task automatic wait_ready();
        int n;
        n = 0;
        while (data_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            sample_rx();
            n++;
        end
        if (n >= 100) check("wait_ready_timeout", 32'(data_ready), 32'd1);
    endtask

    task automatic run_xfer(input logic [DATA_W-1:0] tx, input logic [SS_W-1:0] sel,
                            input logic [1:0] md, input logic [DATA_W-1:0] slv, input logic lb,
                            input logic [NUM_SS-1:0] exp_ss, input int pulse_at, input int rst_at);
        int busy, ss_bad, leads, valid_k, v0, m0;
        logic prev_sclk;
        busy = 0; ss_bad = 0; leads = 0; valid_k = 0;
        mode = md; cur_mode = md; loopback = lb; slave_tx = slv;
        repeat (2) begin @(negedge clk); sample_rx(); end
        wait_ready();
        tx_data = tx; ss_sel = sel; send = 1'b1;
        exp_q.push_back(lb ? tx : slv);
        v0 = rx_valid_cnt; m0 = mosi_bad; prev_sclk = md[1];
        @(posedge clk);
        for (int k = 1; k <= XFER + 4; k++) begin
            @(negedge clk);
            if (k == 1) send = 1'b0;
            sample_rx();
            if (data_ready === 1'b0) begin
                busy++;
                if (ss !== exp_ss) ss_bad++;
            end
            if (sclk !== prev_sclk && sclk !== md[1]) leads++;
            prev_sclk = sclk;
            if (rx_valid === 1'b1 && valid_k == 0) valid_k = k;
            if (pulse_at != 0 && k == pulse_at) begin
                send = 1'b1; tx_data = ~tx; mode = ~md; ss_sel = ~sel;
            end
            if (pulse_at != 0 && k == pulse_at + 1) send = 1'b0;
            if (pulse_at != 0 && k == pulse_at + 10) mode = md;
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                exp_q.delete();
            end
            if (rst_at != 0 && k == rst_at + 1) begin
                check("rst_ss", 32'(ss), 32'(2'b11));
                check("rst_sclk", 32'(sclk), 32'd0);
                check("rst_mosi", 32'(mosi), 32'd0);
                check("rst_data_ready", 32'(data_ready), 32'd1);
                check("rst_rx_valid", 32'(rx_valid), 32'd0);
                rst = 1'b0;
                return;
            end
        end
        check("busy_cycles", busy, BUSY_EXP);
        check("ss_during_xfer_bad", ss_bad, 0);
        check("sclk_leading_edges", leads, DATA_W);
        check("rx_valid_latency", valid_k, XFER + 1);
        check("rx_valid_count", rx_valid_cnt - v0, 1);
        check("ss_after_xfer", 32'(ss), 32'(2'b11));
        check("slave_rx", 32'(s_rx), 32'(tx));
        check("mosi_off_drive_edge", mosi_bad - m0, 0);
    endtask

    // directed sequence
    int acc2, v1, v2, ss_high, vc;
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ss", 32'(ss), 32'(2'b11));
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_data_ready", 32'(data_ready), 32'd1);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;

        // mode 0 loopback, select 0
        run_xfer(8'hA5, 1'b0, 2'b00, 8'h00, 1'b1, 2'b10, 0, 0);

        // mode 3 with slave returning 0x3C, select 1
        mode = 2'b11; cur_mode = 2'b11;
        repeat (2) @(negedge clk);
        check("sclk_idle_cpol1", 32'(sclk), 32'd1);
        run_xfer(8'hC3, 1'b1, 2'b11, 8'h3C, 1'b0, 2'b01, 0, 0);
        check("sclk_idle_after_mode3", 32'(sclk), 32'd1);

        // modes 1 and 2
        run_xfer(8'h81, 1'b0, 2'b01, 8'h7E, 1'b0, 2'b10, 0, 0);
        run_xfer(8'h81, 1'b1, 2'b10, 8'hE7, 1'b0, 2'b01, 0, 0);

        // send pulse and input changes mid-transfer are ignored
        run_xfer(8'h96, 1'b0, 2'b00, 8'h00, 1'b1, 2'b10, 10, 0);

        // reset mid-transfer, then a clean transfer
        run_xfer(8'h99, 1'b0, 2'b00, 8'h00, 1'b1, 2'b10, 0, 15);
        vc = rx_valid_cnt;
        repeat (40) begin @(negedge clk); sample_rx(); end
        check("no_rx_valid_after_rst", rx_valid_cnt - vc, 0);
        run_xfer(8'h5A, 1'b0, 2'b00, 8'h00, 1'b1, 2'b10, 0, 0);

        // send held high across two words
        loopback = 1'b1; mode = 2'b00; cur_mode = 2'b00;
        repeat (2) begin @(negedge clk); sample_rx(); end
        wait_ready();
        tx_data = 8'h11; ss_sel = 1'b0; send = 1'b1;
        exp_q.push_back(8'h11);
        acc2 = 0; v1 = 0; v2 = 0; ss_high = 0; vc = rx_valid_cnt;
        @(posedge clk);
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (k == 1) tx_data = 8'h22;
            if (acc2 != 0 && send) begin
                send = 1'b0;
            end else if (acc2 == 0 && send && data_ready === 1'b1) begin
                acc2 = 1;
                exp_q.push_back(8'h22);
            end
            if (rx_valid === 1'b1) begin
                if (v1 == 0) v1 = k;
                else if (v2 == 0) v2 = k;
            end
            if (ss_idle && v2 == 0) ss_high++;
            sample_rx();
        end
        check("back_to_back_accepted", acc2, 1);
        check("back_to_back_rx_count", rx_valid_cnt - vc, 2);
        check("back_to_back_gap", v2 - v1, GAP_EXP);
        check("back_to_back_ss_high", ss_high, SS_HI_EXP);
        check("back_to_back_slave_rx", 32'(s_rx), 32'h22);

        repeat (5) begin @(negedge clk); sample_rx(); end
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
